// File: rtl/swt_debounce_pkg.sv
// Shared board constants and types for the slide-switch conditioning stage.
package swt_debounce_pkg;

   localparam int unsigned CLK_HZ          = 100_000_000;
   localparam int unsigned DEBOUNCE_MS     = 10;
   localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned SWT_W           = 4;

   // Per-bit debounce state; derived each cycle from synced level vs clean level
   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } db_state_e;

endpackage

// File: rtl/swt_debounce_if.sv
// Raw switch inputs and conditioned outputs of the debounce stage.
interface swt_debounce_if
   import swt_debounce_pkg::*;
#(
   parameter int unsigned WIDTH = SWT_W
);
   logic [WIDTH-1:0] swt;
   logic [WIDTH-1:0] swt_db;
   logic             swt_chg;

   modport master (output swt, input swt_db, input swt_chg);
   modport slave  (input swt, output swt_db, output swt_chg);
endinterface

// File: rtl/swt_debounce_bit.sv
// One switch bit: two-flop synchroniser, settle counter and clean level register.
module swt_debounce_bit
   import swt_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic upd
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   db_state_e        state_c;

   // State register: synchroniser, counter, clean level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else begin
         s1_q  <= din;
         s2_q  <= s1_q;
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

   assign state_c = (s2_q != lvl_q) ? ST_SETTLING : ST_STABLE;

   // Next-state: count while the synced level disagrees, accept at the limit
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      unique case (state_c)
         ST_STABLE: cnt_d = '0;
         ST_SETTLING: begin
            if (cnt_q == CNT_MAX) begin
               lvl_d = s2_q;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Outputs: upd flags the edge on which the clean level is about to change
   always_comb begin
      upd = 1'b0;
      if (state_c == ST_SETTLING && cnt_q == CNT_MAX) upd = 1'b1;
   end

   assign dout = lvl_q;

endmodule

// File: rtl/swt_debounce.sv
// Debounces the slide-switch vector and raises a one-cycle strobe on any clean update.
module swt_debounce
   import swt_debounce_pkg::*;
#(
   parameter int unsigned WIDTH         = SWT_W,
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  logic           CLK100MHZ,
   input  logic           CPU_RESETN,
   swt_debounce_if.slave  sw_if
);

   logic [WIDTH-1:0] db_c;
   logic [WIDTH-1:0] upd_c;
   logic             chg_q;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      swt_debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clk   (CLK100MHZ),
         .rst_n (CPU_RESETN),
         .din   (sw_if.swt[i]),
         .dout  (db_c[i]),
         .upd   (upd_c[i])
      );
   end

   // Strobe aligns with the cycle in which the clean vector shows its new value
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) chg_q <= 1'b0;
      else             chg_q <= |upd_c;
   end

   assign sw_if.swt_db  = db_c;
   assign sw_if.swt_chg = chg_q;

endmodule

// File: tb/tb_swt_debounce.sv
// Randomised and directed stimulus for swt_debounce against a sliding-window reference model.
module tb_swt_debounce;

   localparam int unsigned W = 4;
   localparam int unsigned N = 4;

   logic CLK100MHZ = 1'b0;
   logic CPU_RESETN;

   swt_debounce_if #(.WIDTH(W)) sw_if ();

   swt_debounce #(
      .WIDTH         (W),
      .STABLE_CYCLES (N)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .sw_if      (sw_if)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int n_vec = 0;
   int n_err = 0;

   // Reference: two-stage delay, then a bit flips once its last N synced samples all oppose it
   logic [W-1:0] m_s1, m_s2, m_db;
   logic         m_chg;
   logic [W-1:0] hist [N];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_chg = 1'b0;
      for (int k = 0; k < int'(N); k++) hist[k] = '0;
   endtask

   task automatic model_edge(input logic [W-1:0] v);
      logic [W-1:0] all_opp;
      for (int k = int'(N) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = m_s2;
      all_opp = '1;
      for (int k = 0; k < int'(N); k++) all_opp &= ~(hist[k] ^ ~m_db);
      m_chg = (all_opp != '0);
      m_db  = m_db ^ all_opp;
      m_s2  = m_s1;
      m_s1  = v;
   endtask

   // One clock: drive at the falling edge, update model at the rising edge, compare at next falling edge
   task automatic step(input logic [W-1:0] v, input logic rstn);
      sw_if.swt  = v;
      CPU_RESETN = rstn;
      @(posedge CLK100MHZ);
      if (!rstn) model_reset();
      else       model_edge(v);
      @(negedge CLK100MHZ);
      if (!CPU_RESETN) model_reset();
      check_val("swt_db",  32'(sw_if.swt_db),  32'(m_db));
      check_val("swt_chg", 32'(sw_if.swt_chg), 32'(m_chg));
   endtask

   task automatic hold(input logic [W-1:0] v, input logic rstn, input int cycles);
      for (int c = 0; c < cycles; c++) step(v, rstn);
   endtask

   initial begin
      CPU_RESETN = 1'b1;
      sw_if.swt  = '0;
      model_reset();
      #2;
      CPU_RESETN = 1'b0;
      sw_if.swt  = 4'hF;
      #1;
      check_val("reset_db",  32'(sw_if.swt_db),  32'h0);
      check_val("reset_chg", 32'(sw_if.swt_chg), 32'h0);

      // Reset held with all switches up, then released
      hold(4'hF, 1'b0, 3);
      hold(4'hF, 1'b1, 8);
      // Clean step
      hold(4'h0, 1'b1, 8);
      hold(4'h5, 1'b1, 8);
      // Bounce on bit 0
      hold(4'h0, 1'b1, 8);
      hold(4'h1, 1'b1, 1); hold(4'h0, 1'b1, 1);
      hold(4'h1, 1'b1, 1); hold(4'h0, 1'b1, 1);
      hold(4'h1, 1'b1, 8);
      // Glitch boundary on bit 1: N-1 rejected, N accepted
      hold(4'h0, 1'b1, 8);
      hold(4'h2, 1'b1, 3);
      hold(4'h0, 1'b1, 8);
      hold(4'h2, 1'b1, 4);
      hold(4'h0, 1'b1, 10);
      // Reset mid-settle on bit 2
      hold(4'h4, 1'b1, 4);
      hold(4'h4, 1'b0, 2);
      hold(4'h4, 1'b1, 8);
      // Staggered bits 2 and 3
      hold(4'h0, 1'b1, 8);
      hold(4'h4, 1'b1, 1);
      hold(4'hC, 1'b1, 8);

      // Random excursions of varying width with occasional resets
      for (int t = 0; t < 150; t++) begin
         logic [W-1:0] v;
         logic         r;
         v = W'($urandom);
         r = ($urandom_range(0, 19) != 0);
         hold(v, r, r ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 2)));
      end
      hold(sw_if.swt, 1'b1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
